keccak_pad_unit: RTL
====================

KECCAK_PAD_UNIT -- requirements
Module: keccak_pad_unit

Interface
REQ-001 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  one-cycle pulse that begins a message; honoured only in IDLE.
- keccak_mode_i  in  MODE_SEL_WIDTH  hash mode, sampled with start_i.
- msg_data_i  in  64  message lane; byte k occupies bits [8k+7:8k].
- msg_bytes_i  in  4  valid byte count, 0..8; sampled only on the last beat.
- msg_last_i  in  1  marks the final message beat.
- msg_valid_i  in  1  message beat valid.
- msg_ready_o  out  1  message beat accepted this cycle when msg_valid_i is also high.
- block_o  out  MAX_RATE_BITS  rate block; lane j occupies bits [64j+63:64j].
- block_valid_o  out  1  block_o is valid.
- block_last_o  out  1  the current block is the final, padded block.
- block_ready_i  in  1  downstream accepts the block.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-002 The FSM SHALL have the states IDLE, ABSORB, EMIT and PAD.
REQ-003 In IDLE, start_i with a valid mode SHALL latch rate_lanes and the suffix byte and move to ABSORB; an invalid mode SHALL be ignored.
REQ-004 rate_lanes SHALL be 17 (SHA3_256), 9 (SHA3_512), 21 (SHAKE128) or 17 (SHAKE256); rate_bytes = 8 x rate_lanes.
REQ-005 msg_ready_o SHALL be high only in ABSORB.
REQ-006 Each accepted beat SHALL be written to buffer lane lane_idx, and lane_idx SHALL then increment.
REQ-007 Non-last beats SHALL carry 8 bytes; msg_bytes_i SHALL be ignored on non-last beats.
REQ-008 When a non-last beat fills lane rate_lanes-1, the FSM SHALL go to EMIT with block_last_o=0.
REQ-009 On the last beat, with byte position p = 8 x lane_idx + msg_bytes_i:
- if p < rate_bytes, the module SHALL XOR the suffix into byte p and 0x80 into byte rate_bytes-1, then go to EMIT with last=1;
- if p = rate_bytes-1, that byte SHALL become suffix|0x80 (0x86 or 0x9F).
REQ-010 If the last beat makes p = rate_bytes (block exactly full), the module SHALL go to EMIT with last=0, then PAD.
- PAD SHALL load a zeroed buffer with the suffix in byte 0 and 0x80 in byte rate_bytes-1, then go to EMIT with last=1.
REQ-011 A last beat with msg_bytes_i=0 (including an empty message) SHALL insert no data bytes; padding SHALL follow REQ-009.
REQ-012 Buffer bytes at or above rate_bytes SHALL be driven 0 on block_o.
REQ-013 block_valid_o SHALL rise in the cycle after the triggering beat, or after the PAD cycle.
REQ-014 block_o, block_valid_o and block_last_o SHALL hold stable until block_ready_i is sampled high.
REQ-015 On a block handshake the module SHALL clear the buffer and set lane_idx=0, then go to:
- IDLE if the block was last;
- PAD if a pad block is pending;
- ABSORB otherwise.
REQ-016 No message beat SHALL be accepted while in EMIT or PAD.
REQ-017 start_i outside IDLE SHALL be ignored.

Reset
REQ-018 While rst_ni is low, the module SHALL set:
- state = IDLE;
- buffer, lane_idx and latched parameters = 0;
- msg_ready_o, block_valid_o, block_last_o and busy_o = 0;
- block_o = 0.
REQ-019 Reset asserted mid-message SHALL abort the message with no partial block emitted; after release the module SHALL wait for start_i.

Structure
REQ-020 keccak_pkg SHALL hold MAX_RATE_BITS=1344 and MAX_RATE_LANES=21, alongside the existing mode, rate, capacity and suffix widths and encodings.
REQ-021 keccak_param_unit SHALL be instantiated to decode mode into rate and suffix; rate_lanes = rate/64.
REQ-022 The state enum SHALL be local to the module.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- SHA3_256, empty message (last, 0 bytes) -> one block: byte0=0x06, byte135=0x80, all other bytes 0, last=1.
- SHAKE256, one beat 0x..CCBBAA with 3 bytes -> bytes0-2 = AA,BB,CC; byte3=0x1F; byte135=0x80; last=1.
- SHAKE128, 167 bytes -> one block with byte167=0x9F and last=1.
- SHA3_512, 72 bytes (9 full beats) -> block 1 holds the data with last=0; block 2 has byte0=0x06, byte71=0x80, last=1.
- block_ready_i held low 5 cycles -> block_o stable, msg_ready_o=0; handshake on the 6th cycle.
- rst_ni low after 5 SHA3_256 beats -> all outputs 0, IDLE; a new start_i then works normally.

Source files
------------

// File: rtl/keccak_pkg.sv
// Keccak/SHA-3 shared definitions: mode encodings, rate/capacity/suffix widths
// and per-mode constants used by the padding unit and its parameter decoder.
package keccak_pkg;

  localparam int MODE_SEL_WIDTH = 3;
  localparam int RATE_WIDTH     = 11;
  localparam int CAPACITY_WIDTH = 11;
  localparam int SUFFIX_WIDTH   = 8;

  localparam int MAX_RATE_BITS  = 1344;
  localparam int MAX_RATE_LANES = 21;
  localparam int MAX_RATE_BYTES = MAX_RATE_BITS / 8;
  localparam int LANE_IDX_WIDTH = 5;

  typedef enum logic [MODE_SEL_WIDTH-1:0] {
    MODE_SHA3_256 = 3'd0,
    MODE_SHA3_512 = 3'd1,
    MODE_SHAKE128 = 3'd2,
    MODE_SHAKE256 = 3'd3
  } keccak_mode_e;

  localparam logic [RATE_WIDTH-1:0] RATE_SHA3_256 = 11'd1088;
  localparam logic [RATE_WIDTH-1:0] RATE_SHA3_512 = 11'd576;
  localparam logic [RATE_WIDTH-1:0] RATE_SHAKE128 = 11'd1344;
  localparam logic [RATE_WIDTH-1:0] RATE_SHAKE256 = 11'd1088;

  localparam logic [CAPACITY_WIDTH-1:0] CAP_SHA3_256 = 11'd512;
  localparam logic [CAPACITY_WIDTH-1:0] CAP_SHA3_512 = 11'd1024;
  localparam logic [CAPACITY_WIDTH-1:0] CAP_SHAKE128 = 11'd256;
  localparam logic [CAPACITY_WIDTH-1:0] CAP_SHAKE256 = 11'd512;

  // Domain-separation suffix including the first pad10*1 bit.
  localparam logic [SUFFIX_WIDTH-1:0] SUFFIX_SHA3  = 8'h06;
  localparam logic [SUFFIX_WIDTH-1:0] SUFFIX_SHAKE = 8'h1F;
  localparam logic [7:0]              PAD_LAST     = 8'h80;

endpackage

// File: rtl/keccak_param_unit.sv
// Decodes a hash mode into its rate (bits) and suffix byte.
// Ports: mode (in) selected mode; mode_valid (out) mode is a known encoding;
//        rate (out) rate in bits; suffix (out) domain suffix byte.
module keccak_param_unit
  import keccak_pkg::*;
(
  input  logic [MODE_SEL_WIDTH-1:0] mode,
  output logic                      mode_valid,
  output logic [RATE_WIDTH-1:0]     rate,
  output logic [SUFFIX_WIDTH-1:0]   suffix
);

  always_comb begin
    mode_valid = 1'b0;
    rate       = '0;
    suffix     = '0;
    case (mode)
      MODE_SHA3_256: begin mode_valid = 1'b1; rate = RATE_SHA3_256; suffix = SUFFIX_SHA3;  end
      MODE_SHA3_512: begin mode_valid = 1'b1; rate = RATE_SHA3_512; suffix = SUFFIX_SHA3;  end
      MODE_SHAKE128: begin mode_valid = 1'b1; rate = RATE_SHAKE128; suffix = SUFFIX_SHAKE; end
      MODE_SHAKE256: begin mode_valid = 1'b1; rate = RATE_SHAKE256; suffix = SUFFIX_SHAKE; end
      default: ;
    endcase
  end

endmodule

// File: rtl/keccak_pad_unit.sv
// Keccak padding unit: absorbs 64-bit message beats into a rate-sized buffer,
// applies suffix + pad10*1 padding and hands out full rate blocks.
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/keccak_mode_i
//        begin a message; msg_* message beat stream (valid/ready); block_*
//        rate block stream (valid/ready, last marks the padded block);
//        busy_o high outside IDLE.
module keccak_pad_unit
  import keccak_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
  input  logic [63:0]               msg_data_i,
  input  logic [3:0]                msg_bytes_i,
  input  logic                      msg_last_i,
  input  logic                      msg_valid_i,
  output logic                      msg_ready_o,
  output logic [MAX_RATE_BITS-1:0]  block_o,
  output logic                      block_valid_o,
  output logic                      block_last_o,
  input  logic                      block_ready_i,
  output logic                      busy_o
);

  typedef enum logic [1:0] {IDLE, ABSORB, EMIT, PAD} state_e;

  state_e                              state_q, state_d;
  logic [MAX_RATE_BYTES-1:0][7:0]      buf_q, buf_d;
  logic [LANE_IDX_WIDTH-1:0]           lane_q, lane_d;
  logic [LANE_IDX_WIDTH-1:0]           rl_q, rl_d;     // rate in lanes
  logic [SUFFIX_WIDTH-1:0]             sfx_q, sfx_d;
  logic                                last_q, last_d;
  logic                                pend_q, pend_d; // pad-only block owed

  logic                  mode_valid;
  logic [RATE_WIDTH-1:0] rate;
  logic [SUFFIX_WIDTH-1:0] suffix;
  logic                  unused_rate_lsbs;
  logic [3:0]            nbytes;
  logic [7:0]            pos;
  logic [7:0]            rate_bytes;

  keccak_param_unit u_param (
    .mode       (keccak_mode_i),
    .mode_valid (mode_valid),
    .rate       (rate),
    .suffix     (suffix)
  );

  // Rates are whole lanes, so the low six bits are always zero.
  assign unused_rate_lsbs = ^rate[5:0];

  // Non-last beats are always full; byte counts above 8 saturate.
  assign nbytes     = !msg_last_i ? 4'd8 : (msg_bytes_i > 4'd8) ? 4'd8 : msg_bytes_i;
  assign pos        = {lane_q, 3'b000} + {4'b0000, nbytes};
  assign rate_bytes = {rl_q, 3'b000};

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    lane_d  = lane_q;
    rl_d    = rl_q;
    sfx_d   = sfx_q;
    last_d  = last_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && mode_valid) begin
          rl_d    = rate[RATE_WIDTH-1:6];
          sfx_d   = suffix;
          lane_d  = '0;
          buf_d   = '0;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = ABSORB;
        end
      end
      ABSORB: begin
        if (msg_valid_i) begin
          for (int b = 0; b < MAX_RATE_BYTES; b++) begin
            if ((b / 8) == int'(lane_q) && (b % 8) < int'(nbytes))
              buf_d[b] = msg_data_i[8*(b%8) +: 8];
          end
          lane_d = lane_q + 5'd1;
          if (!msg_last_i) begin
            if (lane_q == rl_q - 5'd1) begin
              state_d = EMIT;
              last_d  = 1'b0;
            end
          end else if (pos == rate_bytes) begin
            // Block is exactly full: ship it, then a padding-only block.
            state_d = EMIT;
            last_d  = 1'b0;
            pend_d  = 1'b1;
          end else begin
            // XOR so suffix and final pad bit merge when they hit the same byte.
            for (int b = 0; b < MAX_RATE_BYTES; b++) begin
              if (8'(b) == pos)               buf_d[b] = buf_d[b] ^ sfx_q;
              if (8'(b) == rate_bytes - 8'd1) buf_d[b] = buf_d[b] ^ PAD_LAST;
            end
            state_d = EMIT;
            last_d  = 1'b1;
          end
        end
      end
      EMIT: begin
        if (block_ready_i) begin
          buf_d  = '0;
          lane_d = '0;
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else if (pend_q) begin
            state_d = PAD;
          end else begin
            state_d = ABSORB;
          end
        end
      end
      PAD: begin
        buf_d    = '0;
        buf_d[0] = sfx_q;
        for (int b = 1; b < MAX_RATE_BYTES; b++) begin
          if (8'(b) == rate_bytes - 8'd1) buf_d[b] = PAD_LAST;
        end
        pend_d  = 1'b0;
        last_d  = 1'b1;
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      buf_q   <= '0;
      lane_q  <= '0;
      rl_q    <= '0;
      sfx_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      lane_q  <= lane_d;
      rl_q    <= rl_d;
      sfx_q   <= sfx_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign msg_ready_o   = (state_q == ABSORB);
  assign block_valid_o = (state_q == EMIT);
  assign block_last_o  = (state_q == EMIT) && last_q;
  assign busy_o        = (state_q != IDLE);

  // Lanes beyond the active rate read as zero.
  for (genvar j = 0; j < MAX_RATE_LANES; j++) begin : g_lane
    assign block_o[64*j +: 64] = (5'(j) < rl_q) ? buf_q[8*j+7 : 8*j] : 64'd0;
  end

endmodule
